csr_access_unit: RTL and testbench

- Initiator side of the CSR register-file port: executes Zicsr instructions (CSRRW/CSRRS/CSRRC and the immediate forms CSRRWI/CSRRSI/CSRRCI) as an atomic read-modify-write sequence.
- Drives the file's read address and its write_en/wb_addr/wb_data inputs; consumes its asynchronous read data.
- Sits beside the EX stage; requests and responses use valid/ready handshakes.
- Returns the old CSR value for rd writeback and flags illegal accesses.

---
 rtl/csr_pkg.sv | 22 ++
 rtl/csr_alu.sv | 54 +++++
 rtl/csr_access_unit.sv | 167 ++++++++++++++++
 tb/tb_csr_access_unit.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared encodings for the Zicsr access unit: funct3 opcodes, FSM states and
// the read-only CSR address range.
package csr_pkg;

    localparam logic [2:0] CSR_RW  = 3'b001;
    localparam logic [2:0] CSR_RS  = 3'b010;
    localparam logic [2:0] CSR_RC  = 3'b011;
    localparam logic [2:0] CSR_RWI = 3'b101;
    localparam logic [2:0] CSR_RSI = 3'b110;
    localparam logic [2:0] CSR_RCI = 3'b111;

    // Top two address bits equal to this mark a read-only CSR.
    localparam logic [1:0] CSR_RO_RANGE = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite,
        StResp
    } csr_state_e;

endpackage

// File: rtl/csr_alu.sv
// Combinational read-modify-write datapath: new CSR value, write-needed flag
// and illegal-access detection for one Zicsr instruction.
module csr_alu
    import csr_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned CSR_AW = 12
) (
    input  logic [2:0]        funct3_i,
    input  logic [XLEN-1:0]   old_i,
    input  logic [XLEN-1:0]   operand_i,
    input  logic [4:0]        rs1_idx_i,
    input  logic [CSR_AW-1:0] addr_i,
    output logic [XLEN-1:0]   new_o,
    output logic              do_write_o,
    output logic              illegal_o
);

    logic wants_write;
    logic bad_op;
    logic ro_hit;
    logic zero_addr;

    always_comb begin
        new_o       = operand_i;
        wants_write = 1'b0;
        bad_op      = 1'b0;
        unique case (funct3_i[1:0])
            2'b01: begin
                new_o       = operand_i;
                wants_write = 1'b1;
            end
            2'b10: begin
                new_o       = old_i | operand_i;
                wants_write = (rs1_idx_i != 5'd0);
            end
            2'b11: begin
                new_o       = old_i & ~operand_i;
                wants_write = (rs1_idx_i != 5'd0);
            end
            default: begin
                bad_op = 1'b1;
            end
        endcase
    end

    assign ro_hit    = (addr_i[CSR_AW-1 -: 2] == CSR_RO_RANGE);
    assign zero_addr = (addr_i == '0);

    // Reads of address 0 and of read-only CSRs stay legal; only writes trap.
    assign illegal_o  = bad_op | (wants_write & (ro_hit | zero_addr));
    assign do_write_o = wants_write & ~illegal_o;

endmodule

// File: rtl/csr_access_unit.sv
// Initiator side of the CSR register-file port: runs one Zicsr instruction as
// an atomic read / write / respond sequence with valid-ready handshakes.
module csr_access_unit
    import csr_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned CSR_AW = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_funct3,
    input  logic [CSR_AW-1:0] req_csr_addr,
    input  logic [XLEN-1:0]   req_rs1_data,
    input  logic [4:0]        req_rs1_idx,
    input  logic [4:0]        req_rd,
    input  logic              flush,
    output logic [CSR_AW-1:0] csr_addr,
    input  logic [XLEN-1:0]   csr_rdata,
    output logic              csr_write_en,
    output logic [CSR_AW-1:0] csr_wb_addr,
    output logic [XLEN-1:0]   csr_wb_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [4:0]        resp_rd,
    output logic [XLEN-1:0]   resp_data,
    output logic              resp_illegal
);

    csr_state_e        state_q, state_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [CSR_AW-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   operand_q, operand_d;
    logic [4:0]        rs1_idx_q, rs1_idx_d;
    logic [4:0]        rd_q, rd_d;
    logic [XLEN-1:0]   old_q, old_d;
    logic [XLEN-1:0]   new_q, new_d;
    logic              illegal_q, illegal_d;
    logic              write_en_q, write_en_d;
    logic              resp_valid_q, resp_valid_d;
    logic              req_ready_q, req_ready_d;

    logic [XLEN-1:0]   alu_new;
    logic              alu_do_write;
    logic              alu_illegal;

    csr_alu #(
        .XLEN   (XLEN),
        .CSR_AW (CSR_AW)
    ) u_csr_alu (
        .funct3_i   (funct3_q),
        .old_i      (csr_rdata),
        .operand_i  (operand_q),
        .rs1_idx_i  (rs1_idx_q),
        .addr_i     (addr_q),
        .new_o      (alu_new),
        .do_write_o (alu_do_write),
        .illegal_o  (alu_illegal)
    );

    always_comb begin
        state_d      = state_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        operand_d    = operand_q;
        rs1_idx_d    = rs1_idx_q;
        rd_d         = rd_q;
        old_d        = old_q;
        new_d        = new_q;
        illegal_d    = illegal_q;
        write_en_d   = 1'b0;
        resp_valid_d = resp_valid_q;
        req_ready_d  = req_ready_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid && !flush) begin
                    funct3_d    = req_funct3;
                    addr_d      = req_csr_addr;
                    rs1_idx_d   = req_rs1_idx;
                    rd_d        = req_rd;
                    // Immediate forms reuse the rs1 index field as a 5-bit uimm.
                    operand_d   = req_funct3[2] ? {{(XLEN-5){1'b0}}, req_rs1_idx}
                                                : req_rs1_data;
                    req_ready_d = 1'b0;
                    state_d     = StRead;
                end
            end
            StRead: begin
                if (flush) begin
                    req_ready_d = 1'b1;
                    state_d     = StIdle;
                end else begin
                    old_d      = alu_illegal ? '0 : csr_rdata;
                    new_d      = alu_new;
                    illegal_d  = alu_illegal;
                    write_en_d = alu_do_write;
                    state_d    = StWrite;
                end
            end
            StWrite: begin
                if (flush) begin
                    req_ready_d = 1'b1;
                    state_d     = StIdle;
                end else begin
                    resp_valid_d = 1'b1;
                    state_d      = StResp;
                end
            end
            StResp: begin
                if (flush || resp_ready) begin
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = StIdle;
                end
            end
            default: begin
                resp_valid_d = 1'b0;
                req_ready_d  = 1'b1;
                state_d      = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            funct3_q     <= '0;
            addr_q       <= '0;
            operand_q    <= '0;
            rs1_idx_q    <= '0;
            rd_q         <= '0;
            old_q        <= '0;
            new_q        <= '0;
            illegal_q    <= 1'b0;
            write_en_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            funct3_q     <= funct3_d;
            addr_q       <= addr_d;
            operand_q    <= operand_d;
            rs1_idx_q    <= rs1_idx_d;
            rd_q         <= rd_d;
            old_q        <= old_d;
            new_q        <= new_d;
            illegal_q    <= illegal_d;
            write_en_q   <= write_en_d;
            resp_valid_q <= resp_valid_d;
            req_ready_q  <= req_ready_d;
        end
    end

    // The file commits on negedge; a flush anywhere in the WRITE cycle must veto it.
    assign csr_write_en = write_en_q & ~flush;
    assign csr_addr     = addr_q;
    assign csr_wb_addr  = addr_q;
    assign csr_wb_data  = new_q;
    assign req_ready    = req_ready_q;
    assign resp_valid   = resp_valid_q;
    assign resp_rd      = rd_q;
    assign resp_data    = old_q;
    assign resp_illegal = illegal_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// Randomized self-checking bench for csr_access_unit against a CSR-file model
// and an instruction-level reference model.
module tb_csr_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [11:0] req_csr_addr;
    logic [31:0] req_rs1_data;
    logic [4:0]  req_rs1_idx;
    logic [4:0]  req_rd;
    logic        flush;
    logic [11:0] csr_addr;
    logic [31:0] csr_rdata;
    logic        csr_write_en;
    logic [11:0] csr_wb_addr;
    logic [31:0] csr_wb_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [4:0]  resp_rd;
    logic [31:0] resp_data;
    logic        resp_illegal;

    int n_cmp = 0;
    int n_err = 0;

    csr_access_unit #(
        .XLEN   (32),
        .CSR_AW (12)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_funct3   (req_funct3),
        .req_csr_addr (req_csr_addr),
        .req_rs1_data (req_rs1_data),
        .req_rs1_idx  (req_rs1_idx),
        .req_rd       (req_rd),
        .flush        (flush),
        .csr_addr     (csr_addr),
        .csr_rdata    (csr_rdata),
        .csr_write_en (csr_write_en),
        .csr_wb_addr  (csr_wb_addr),
        .csr_wb_data  (csr_wb_data),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rd      (resp_rd),
        .resp_data    (resp_data),
        .resp_illegal (resp_illegal)
    );

    always #5 clk = ~clk;

    // CSR file model: asynchronous read, write on negedge.
    logic [31:0] csr_mem [4096];
    logic [31:0] ref_mem [4096];
    logic        pre_en = 1'b0;
    logic [11:0] pre_addr = '0;
    logic [31:0] pre_data = '0;
    int          wr_cnt = 0;
    logic [31:0] last_wb_data = '0;
    logic [11:0] last_wb_addr = '0;

    assign csr_rdata = csr_mem[csr_addr];

    always @(negedge clk) begin
        if (pre_en) begin
            csr_mem[pre_addr] <= pre_data;
        end else if (csr_write_en) begin
            csr_mem[csr_wb_addr] <= csr_wb_data;
            wr_cnt               <= wr_cnt + 1;
            last_wb_data         <= csr_wb_data;
            last_wb_addr         <= csr_wb_addr;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        pre_en   = 1'b1;
        pre_addr = a;
        pre_data = d;
        ref_mem[a] = d;
        @(negedge clk);
        #1;
        pre_en = 1'b0;
    endtask

    // Instruction-level reference: what the ISA says a Zicsr op does to one CSR.
    task automatic model(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] rs1d,
                         input logic [4:0] idx, input logic [31:0] cur,
                         output logic [31:0] exp_data, output logic exp_wr,
                         output logic [31:0] exp_new, output logic exp_ill);
        logic [31:0] opnd;
        bit          writes;
        bit          bad;
        opnd    = f3[2] ? {27'd0, idx} : rs1d;
        bad     = 1'b0;
        writes  = 1'b0;
        exp_new = 32'd0;
        if (f3 == 3'b001 || f3 == 3'b101) begin
            writes  = 1'b1;
            exp_new = opnd;
        end else if (f3 == 3'b010 || f3 == 3'b110) begin
            writes  = (idx != 0);
            exp_new = cur | opnd;
        end else if (f3 == 3'b011 || f3 == 3'b111) begin
            writes  = (idx != 0);
            exp_new = cur & ~opnd;
        end else begin
            bad = 1'b1;
        end
        exp_ill  = bad || (writes && (a >= 12'hC00 || a == 12'h000));
        exp_wr   = writes && !exp_ill;
        exp_data = exp_ill ? 32'd0 : cur;
    endtask

    task automatic do_op(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] rs1d,
                         input logic [4:0] idx, input logic [4:0] rd, input int hold,
                         input bit idle_flush);
        logic [31:0] ed;
        logic [31:0] en;
        logic        ew;
        logic        ei;
        int          wr0;
        int          cyc;
        model(f3, a, rs1d, idx, ref_mem[a], ed, ew, en, ei);
        req_funct3   = f3;
        req_csr_addr = a;
        req_rs1_data = rs1d;
        req_rs1_idx  = idx;
        req_rd       = rd;
        req_valid    = 1'b1;
        resp_ready   = (hold == 0);
        check_eq("req_ready_idle", {31'd0, req_ready}, 32'd1);
        if (idle_flush) begin
            flush = 1'b1;
            @(posedge clk);
            #1;
            check_eq("flush_blocks_accept", {31'd0, req_ready}, 32'd1);
            flush = 1'b0;
        end
        wr0 = wr_cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        cyc = 1;
        check_eq("req_ready_busy", {31'd0, req_ready}, 32'd0);
        while (!resp_valid && cyc < 8) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_eq("resp_latency", cyc, 3);
        check_eq("resp_data", resp_data, ed);
        check_eq("resp_rd", {27'd0, resp_rd}, {27'd0, rd});
        check_eq("resp_illegal", {31'd0, resp_illegal}, {31'd0, ei});
        check_eq("write_count", wr_cnt - wr0, {31'd0, ew});
        if (ew) begin
            check_eq("wb_data", last_wb_data, en);
            check_eq("wb_addr", {20'd0, last_wb_addr}, {20'd0, a});
            ref_mem[a] = en;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check_eq("hold_valid", {31'd0, resp_valid}, 32'd1);
            check_eq("hold_data", resp_data, ed);
            check_eq("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("resp_done", {31'd0, resp_valid}, 32'd0);
        check_eq("ready_after", {31'd0, req_ready}, 32'd1);
        check_eq("csr_contents", csr_mem[a], ref_mem[a]);
        resp_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        check_eq({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
        check_eq({tag, "_write_en"}, {31'd0, csr_write_en}, 32'd0);
        check_eq({tag, "_csr_addr"}, {20'd0, csr_addr}, 32'd0);
        check_eq({tag, "_wb_data"}, csr_wb_data, 32'd0);
        check_eq({tag, "_resp_data"}, resp_data, 32'd0);
        check_eq({tag, "_resp_rd"}, {27'd0, resp_rd}, 32'd0);
        check_eq({tag, "_resp_illegal"}, {31'd0, resp_illegal}, 32'd0);
    endtask

    logic [11:0] pool [8];

    initial begin
        int          wr0;
        logic [31:0] cur;
        rst          = 1'b0;
        req_valid    = 1'b0;
        req_funct3   = '0;
        req_csr_addr = '0;
        req_rs1_data = '0;
        req_rs1_idx  = '0;
        req_rd       = '0;
        flush        = 1'b0;
        resp_ready   = 1'b0;
        pool[0] = 12'h000; pool[1] = 12'h300; pool[2] = 12'h341; pool[3] = 12'h305;
        pool[4] = 12'h7C0; pool[5] = 12'hC00; pool[6] = 12'hC01; pool[7] = 12'hFFF;
        preload(12'h000, 32'd0);
        for (int i = 1; i < 8; i++) preload(pool[i], $urandom);
        preload(12'h300, 32'h0000_00F0);
        preload(12'hC00, 32'h1234_5678);
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Directed: set, clear with x0, read-only CSR, backpressure.
        do_op(3'b010, 12'h300, 32'h0000_000F, 5'd5, 5'd3, 0, 1'b0);
        check_eq("rs_result", csr_mem[12'h300], 32'h0000_00FF);
        do_op(3'b011, 12'h300, 32'hFFFF_FFFF, 5'd0, 5'd4, 0, 1'b0);
        do_op(3'b101, 12'hC00, 32'd0, 5'd5, 5'd6, 0, 1'b0);
        do_op(3'b110, 12'hC00, 32'd0, 5'd0, 5'd7, 0, 1'b0);
        do_op(3'b001, 12'h341, 32'hDEAD_BEEF, 5'd8, 5'd10, 5, 1'b0);
        do_op(3'b100, 12'h305, 32'hFFFF_0000, 5'd9, 5'd11, 0, 1'b0);
        do_op(3'b000, 12'h305, 32'hFFFF_0000, 5'd9, 5'd11, 0, 1'b0);
        do_op(3'b001, 12'h000, 32'h5555_5555, 5'd2, 5'd1, 0, 1'b0);
        do_op(3'b010, 12'h000, 32'h0, 5'd0, 5'd1, 1, 1'b1);

        // Flush in the WRITE cycle vetoes the write and the response.
        cur = ref_mem[12'h341];
        wr0 = wr_cnt;
        req_funct3 = 3'b001; req_csr_addr = 12'h341; req_rs1_data = 32'h1111_2222;
        req_rs1_idx = 5'd7; req_rd = 5'd9; req_valid = 1'b1; resp_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check_eq("write_en_pre_flush", {31'd0, csr_write_en}, 32'd1);
        flush = 1'b1;
        #1;
        check_eq("write_en_flushed", {31'd0, csr_write_en}, 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        check_eq("flush_ready", {31'd0, req_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            check_eq("flush_no_resp", {31'd0, resp_valid}, 32'd0);
            @(posedge clk);
            #1;
        end
        check_eq("flush_no_write", wr_cnt - wr0, 32'd0);
        check_eq("flush_csr_kept", csr_mem[12'h341], cur);
        resp_ready = 1'b0;

        // Asynchronous reset during READ, then during WRITE.
        for (int k = 0; k < 2; k++) begin
            cur = ref_mem[12'h305];
            wr0 = wr_cnt;
            req_funct3 = 3'b001; req_csr_addr = 12'h305; req_rs1_data = 32'hA5A5_0F0F;
            req_rs1_idx = 5'd3; req_rd = 5'd12; req_valid = 1'b1;
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            if (k == 1) begin
                @(posedge clk);
                #1;
                check_eq("write_en_pre_rst", {31'd0, csr_write_en}, 32'd1);
            end
            rst = 1'b0;
            #1;
            check_reset_outputs(k == 0 ? "rst_read" : "rst_write");
            @(negedge clk);
            #1;
            rst = 1'b1;
            @(posedge clk);
            #1;
            check_eq("rst_no_write", wr_cnt - wr0, 32'd0);
            check_eq("rst_csr_kept", csr_mem[12'h305], cur);
        end

        // Randomized instruction stream over a small CSR pool.
        for (int n = 0; n < 40; n++) begin
            logic [2:0]  f3;
            logic [4:0]  idx;
            f3  = 3'($urandom_range(0, 7));
            idx = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            do_op(f3, pool[$urandom_range(0, 7)], $urandom, idx, 5'($urandom_range(0, 31)),
                  $urandom_range(0, 2), ($urandom_range(0, 7) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
